round_sat36_18: RTL and testbench
=================================

Name: round_sat36_18

Overview:
- Downstream stage of the 18x18 dual-multiply/add datapath. Consumes its signed 36-bit sum and produces a signed 18-bit sample.
- Applies a run-time arithmetic right shift with round-half-up, then saturates to 18 bits.
- Adds a valid/ready handshake with a 2-stage elastic pipeline, so the MAC output can be held under downstream backpressure.
- Keeps a sticky saturation flag and a saturating event counter for gain-staging debug.

Parameters:
- CNT_W, 16, width of saturation event counter
- MAX_SHIFT, 18, largest honoured shift; larger shift values clamp to this

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  x is valid this cycle
- in_ready  out  1  block accepts x this cycle
- x  in  36  signed input (multiply-add result)
- shift  in  5  right-shift amount, sampled with x on accept
- out_valid  out  1  y is valid
- out_ready  in  1  downstream accepts y
- y  out  18  signed rounded/saturated result
- y_sat  out  1  this y was saturated
- sat_sticky  out  1  set on any saturated output handshake
- sat_cnt  out  CNT_W  count of saturated output handshakes
- clr_stat  in  1  synchronous clear of sat_sticky and sat_cnt

Behaviour:
- Reset:
  - One clock `clk`; reset is asynchronous and active-low on `reset_n`.
  - Asserting reset_n low clears all valids, data regs, y, y_sat, sat_sticky and sat_cnt to 0, immediately and at any point.
  - Reset mid-transfer drops all in-flight samples. First accept after release behaves as from empty.
- Handshake:
  - Accept on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - y, y_sat stay stable while out_valid && !out_ready.
- Pipeline registers:
  - Stage 1 (s1): holds the shifted 37-bit value and its valid.
  - Stage 2 (s2): is the output register (y, y_sat, out_valid).
- Advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready; no in_valid→in_ready path.
- Latency and throughput:
  - Accept at cycle N gives out_valid at N+2 when unstalled.
  - Throughput is 1 sample/clk with out_ready high.
  - At most 2 samples are buffered.
- Stage 1 arithmetic:
  - Clamp: s = min(shift, MAX_SHIFT).
  - Sign-extend x to 37 bits; add rnd = (s==0) ? 0 : 2^(s-1); arithmetic shift right by s.
  - The 37-bit sum never overflows.
  - Round-half-up means toward +inf at exact .5: 2.5→3, −2.5→−2.
- Stage 2 saturation:
  - If the value > 131071, y = 131071 (0x1FFFF) and y_sat = 1.
  - If the value < −131072, y = −131072 (0x20000) and y_sat = 1.
  - Otherwise y = the low 18 bits and y_sat = 0.
- Statistics:
  - sat_evt = out_valid && out_ready && y_sat.
  - sat_sticky sets on sat_evt.
  - sat_cnt increments on sat_evt and holds at all-ones (no wrap).
  - clr_stat wins over a simultaneous sat_evt: both clear to 0 that cycle.
- Bubbles: s1 empty with s2 full and out_ready low → in_ready = 1 (s1 fills). Both full and out_ready low → in_ready = 0.

Decomposition:
- Shared package (dsp_pkg):
  - IN_W = 36, OUT_W = 18
  - SAT_MAX = 18'sh1FFFF, SAT_MIN = 18'sh20000
  - a typedef for the signed 18-bit sample and the signed 36-bit MAC word
  - MAX_SHIFT default
- Natural sub-module: round_shift37, a combinational clamp + round + shift function used in stage 1. Handshake and counters stay in the top.

Test Plan:
- Unstalled basics:
  - shift=0, x=100 → y=100, y_sat=0, exactly 2 clk after accept.
  - Then x=−5 back-to-back → y=−5 on the next cycle.
- Rounding:
  - shift=4, x=40 → y=3.
  - shift=4, x=−40 → y=−2.
  - shift=4, x=24 → y=2 (1.5→2).
  - shift=31 clamps to 18: x=2^35−1 → y=131071, y_sat=1.
- Saturation and stats:
  - shift=0, x=200000 → y=131071, y_sat=1.
  - x=−200000 → y=−131072, y_sat=1.
  - After both transfers: sat_cnt=2, sat_sticky=1.
  - Pulse clr_stat on the same cycle as a third saturated transfer → sat_cnt=0, sat_sticky=0.
- Backpressure:
  - out_ready=0, offer 3 samples (1,2,3) continuously → 2 accepted, then in_ready=0.
  - y holds 1 unchanged.
  - Raise out_ready → y sequence 1,2,3 with no loss or duplication; in_ready returns to 1 the same cycle out_ready rises.
- Counter saturation: CNT_W=4, force 17 saturated transfers → sat_cnt stays at 15.
- Reset mid-operation:
  - Stall with 2 samples held, pulse reset_n low asynchronously (between edges) → out_valid=0, y=0, sat_cnt=0 immediately.
  - After release, x=7, shift=0 → y=7 two cycles later.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared widths, sample types and the 37-bit to 18-bit saturation helper
// for the multiply/add datapath back end.
package dsp_pkg;

  localparam int unsigned IN_W          = 36;
  localparam int unsigned OUT_W         = 18;
  localparam int unsigned EXT_W         = IN_W + 1;
  localparam int unsigned SHIFT_W       = 5;
  localparam int unsigned MAX_SHIFT_DEF = 18;

  typedef logic signed [OUT_W-1:0] sample_t;
  typedef logic signed [IN_W-1:0]  mac_t;
  typedef logic signed [EXT_W-1:0] ext_t;

  localparam sample_t SAT_MAX = 18'sh1FFFF;
  localparam sample_t SAT_MIN = 18'sh20000;

  // Output stage payload: the sample plus its saturation marker.
  typedef struct packed {
    logic    sat;
    sample_t y;
  } out_word_t;

  // Clamp a rounded 37-bit value into the signed 18-bit sample range.
  function automatic out_word_t saturate(input ext_t v);
    out_word_t r;
    r.sat = 1'b0;
    r.y   = sample_t'(v[OUT_W-1:0]);
    if (v > ext_t'(SAT_MAX)) begin
      r.sat = 1'b1;
      r.y   = SAT_MAX;
    end else if (v < ext_t'(SAT_MIN)) begin
      r.sat = 1'b1;
      r.y   = SAT_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_shift37.sv
// Combinational shift clamp, round-half-up bias and arithmetic right shift
// of the sign-extended 36-bit MAC word.
module round_shift37
  import dsp_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic [IN_W-1:0]    x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [EXT_W-1:0]   y_c
);

  logic [SHIFT_W-1:0] s_c;
  mac_t               x_s_c;
  ext_t               ext_c;
  ext_t               rnd_c;
  ext_t               sum_c;

  // Adding half an LSB of the result before flooring rounds ties toward +inf.
  always_comb begin
    s_c   = (32'(shift_i) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT) : shift_i;
    x_s_c = mac_t'(x_i);
    ext_c = ext_t'(x_s_c);
    rnd_c = '0;
    if (s_c != '0) begin
      rnd_c = ext_t'(1) << (s_c - SHIFT_W'(1));
    end
    sum_c = ext_c + rnd_c;
    y_c   = sum_c >>> s_c;
  end

endmodule

// File: rtl/round_sat36_18.sv
// Round/shift/saturate stage with a 2-deep elastic valid/ready pipeline and
// sticky saturation statistics.
module round_sat36_18
  import dsp_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    x,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   y,
  output logic               y_sat,
  output logic               sat_sticky,
  output logic [CNT_W-1:0]   sat_cnt,
  input  logic               clr_stat
);

  logic [EXT_W-1:0] shifted_c;
  logic             s2_load_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             sat_evt_c;
  out_word_t        sat_word_c;

  logic             s1_valid_q, s1_valid_d;
  ext_t             s1_val_q,   s1_val_d;
  logic             out_valid_q, out_valid_d;
  out_word_t        out_q,      out_d;
  logic             sticky_q,   sticky_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  round_shift37 #(
    .MAX_SHIFT (MAX_SHIFT)
  ) u_round_shift37 (
    .x_i     (x),
    .shift_i (shift),
    .y_c     (shifted_c)
  );

  // Handshake, pipeline advance and statistics next-state.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_val_d    = s1_val_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    s2_load_c  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready_c = !s1_valid_q || s2_load_c;
    accept_c   = in_valid && in_ready_c;
    sat_evt_c  = out_valid_q && out_ready && out_q.sat;
    sat_word_c = saturate(s1_val_q);

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_val_d   = ext_t'(shifted_c);
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end

    // y/y_sat only change on a load, so they hold while stalled.
    if (s2_load_c) begin
      out_valid_d = 1'b1;
      out_d       = sat_word_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr_stat) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (sat_evt_c) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign y          = out_q.y;
  assign y_sat      = out_q.sat;
  assign sat_sticky = sticky_q;
  assign sat_cnt    = cnt_q;

endmodule

// File: tb/tb_round_sat36_18.sv
// Bench for round_sat36_18: a queue-based reference of the elastic buffer and
// statistics, checked every cycle, plus literal expectations for key vectors.
module tb_round_sat36_18;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [35:0] x;
  logic [4:0]  shift;
  logic        out_ready;
  logic        clr_stat;

  logic               in_ready16, out_valid16, ysat16, sticky16;
  logic signed [17:0] y16;
  logic [15:0]        cnt16;
  logic               in_ready4, out_valid4, ysat4, sticky4;
  logic signed [17:0] y4;
  logic [3:0]         cnt4;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct { longint y; bit sat; bit aged; } item_t;
  typedef struct { longint y; bit sat; int cyc; } obs_t;
  item_t mq[$];
  obs_t  obs[$];
  bit    m_sticky = 0;
  int    m_cnt16  = 0;
  int    m_cnt4   = 0;

  round_sat36_18 dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .x(x), .shift(shift), .out_valid(out_valid16), .out_ready(out_ready),
    .y(y16), .y_sat(ysat16), .sat_sticky(sticky16), .sat_cnt(cnt16),
    .clr_stat(clr_stat)
  );

  round_sat36_18 #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x), .shift(shift), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .y_sat(ysat4), .sat_sticky(sticky4), .sat_cnt(cnt4),
    .clr_stat(clr_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: floor((x + d/2) / d) with d = 2^min(shift,18), then clamp.
  function automatic longint ref_val(input longint xv, input int sh, output bit sat);
    int     s;
    longint d, num, q;
    s   = (sh > 18) ? 18 : sh;
    d   = longint'(1) << s;
    num = xv + ((s == 0) ? 0 : d / 2);
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    sat = 1'b0;
    if (q > 131071)  begin q = 131071;  sat = 1'b1; end
    if (q < -131072) begin q = -131072; sat = 1'b1; end
    return q;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt16  = 0;
      m_cnt4   = 0;
    end else begin
      bit     vis, m_ready, xfer, s;
      longint xs, v;
      item_t  it;
      vis     = (mq.size() > 0) && mq[0].aged;
      m_ready = (mq.size() < 2) || out_ready;
      check("out_valid", longint'(out_valid16), longint'(vis));
      check("out_valid_c4", longint'(out_valid4), longint'(vis));
      check("in_ready", longint'(in_ready16), longint'(m_ready));
      check("in_ready_c4", longint'(in_ready4), longint'(m_ready));
      if (vis) begin
        check("y", longint'(y16), mq[0].y);
        check("y_c4", longint'(y4), mq[0].y);
        check("y_sat", longint'(ysat16), longint'(mq[0].sat));
        check("y_sat_c4", longint'(ysat4), longint'(mq[0].sat));
      end
      check("sat_sticky", longint'(sticky16), longint'(m_sticky));
      check("sat_sticky_c4", longint'(sticky4), longint'(m_sticky));
      check("sat_cnt", longint'(cnt16), longint'(m_cnt16));
      check("sat_cnt_c4", longint'(cnt4), longint'(m_cnt4));

      xfer = vis && out_ready;
      if (xfer) obs.push_back('{y: longint'(y16), sat: ysat16, cyc: cyc});
      if (clr_stat) begin
        m_sticky = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
      end else if (xfer && mq[0].sat) begin
        m_sticky = 1'b1;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (xfer) void'(mq.pop_front());
      foreach (mq[i]) mq[i].aged = 1'b1;
      if (in_valid && m_ready) begin
        xs      = longint'($signed(x));
        v       = ref_val(xs, int'(shift), s);
        it.y    = v; it.sat = s; it.aged = 1'b0;
        mq.push_back(it);
      end
    end
  end

  task automatic send(input longint xv, input int sh, output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    acc_cyc  = -1;
    in_valid = 1'b1;
    x        = 36'(xv);
    shift    = 5'(sh);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready16) begin ok = 1'b1; acc_cyc = cyc; end
    end
    if (!ok) check("send_accept", longint'(ok), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    int a0, a1, n0;
    reset_n = 1'b0; in_valid = 1'b0; x = '0; shift = '0;
    out_ready = 1'b1; clr_stat = 1'b0;
    #3;
    check("rst_out_valid", longint'(out_valid16), 0);
    check("rst_y", longint'(y16), 0);
    check("rst_sat_cnt", longint'(cnt16), 0);
    check("rst_sticky", longint'(sticky16), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Unstalled basics and latency
    n0 = obs.size();
    send(100, 0, a0);
    send(-5, 0, a1);
    idle(4);
    check("basic_count", obs.size(), n0 + 2);
    check("basic_y0", obs[n0].y, 100);
    check("basic_sat0", longint'(obs[n0].sat), 0);
    check("basic_latency", obs[n0].cyc - a0, 2);
    check("basic_y1", obs[n0+1].y, -5);
    check("basic_b2b", obs[n0+1].cyc - obs[n0].cyc, 1);

    // Rounding and shift clamp
    n0 = obs.size();
    send(40, 4, a0);
    send(-40, 4, a0);
    send(24, 4, a0);
    send(64'sd34359738367, 31, a0);
    idle(4);
    check("rnd_pos_half", obs[n0].y, 3);
    check("rnd_neg_half", obs[n0+1].y, -2);
    check("rnd_1p5", obs[n0+2].y, 2);
    check("clamp_y", obs[n0+3].y, 131071);
    check("clamp_sat", longint'(obs[n0+3].sat), 1);

    @(posedge clk); #1 clr_stat = 1'b1;
    @(posedge clk); #1 clr_stat = 1'b0;
    check("clr_cnt", longint'(cnt16), 0);

    // Saturation and statistics
    n0 = obs.size();
    send(200000, 0, a0);
    send(-200000, 0, a0);
    idle(4);
    check("sat_hi", obs[n0].y, 131071);
    check("sat_lo", obs[n0+1].y, -131072);
    check("sat_lo_flag", longint'(obs[n0+1].sat), 1);
    check("stat_cnt2", longint'(cnt16), 2);
    check("stat_sticky", longint'(sticky16), 1);
    send(200000, 0, a0);
    @(posedge clk); #1 clr_stat = 1'b1;
    @(posedge clk); #1 clr_stat = 1'b0;
    check("clr_wins_cnt", longint'(cnt16), 0);
    check("clr_wins_sticky", longint'(sticky16), 0);

    // Backpressure: two buffered, third held off
    n0 = obs.size();
    out_ready = 1'b0;
    in_valid = 1'b1; x = 36'd1; shift = 5'd0;
    @(posedge clk); #1 x = 36'd2;
    @(posedge clk); #1 x = 36'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready16), 0);
      check("bp_y_hold", longint'(y16), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #1 check("bp_ready_same_cycle", longint'(in_ready16), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    idle(4);
    check("bp_count", obs.size(), n0 + 3);
    check("bp_y1", obs[n0].y, 1);
    check("bp_y2", obs[n0+1].y, 2);
    check("bp_y3", obs[n0+2].y, 3);

    // Counter saturation on the narrow instance
    n0 = obs.size();
    for (int i = 0; i < 17; i++) send(200000, 0, a0);
    idle(4);
    check("cnt_count", obs.size(), n0 + 17);
    check("cnt4_hold", longint'(cnt4), 15);
    check("cnt16_17", longint'(cnt16), 17);

    // Asynchronous reset with two samples held
    n0 = obs.size();
    out_ready = 1'b0;
    send(11, 0, a0);
    send(12, 0, a0);
    repeat (2) @(posedge clk);
    #3 check("pre_rst_valid", longint'(out_valid16), 1);
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", longint'(out_valid16), 0);
    check("arst_y", longint'(y16), 0);
    check("arst_sat_cnt", longint'(cnt16), 0);
    check("arst_sticky", longint'(sticky16), 0);
    @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    send(7, 0, a1);
    idle(4);
    check("post_rst_count", obs.size(), n0 + 1);
    check("post_rst_y", obs[obs.size()-1].y, 7);
    check("post_rst_latency", obs[obs.size()-1].cyc - a1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
